// File: rtl/word_unshift_iter.sv
// rtl/word_unshift_iter.sv - iterative one-bit-per-clock word rotate/shift (unmix) engine
//
// Purpose:
//   Undoes a rotate or logical shift on a mixed word. It moves one bit position
//   per clock, so no barrel shifter is needed. There is one operation in flight
//   at a time, with valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input word valid
//   in_ready   block can accept an input word (IDLE)
//   in_data    word to transform
//   in_amt     number of bit positions (0..2^AMT_W-1)
//   in_op      00 rotate right, 01 rotate left, 10 logical shift right, 11 shift left
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   out_data   result word (the working data register itself)
//   busy       high in SHIFT or DONE

module word_unshift_iter #(
  parameter int               WIDTH     = 8,
  parameter int               AMT_W     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'hFC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] step_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // The step that consumes the last position finishes the operation.
        if (cnt_q == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-position step selected by the captured operation
  always_comb begin
    step_data = data_q;
    case (op_q)
      2'b00:   step_data = {data_q[0], data_q[WIDTH-1:1]};
      2'b01:   step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      2'b10:   step_data = {1'b0, data_q[WIDTH-1:1]};
      default: step_data = {data_q[WIDTH-2:0], 1'b0};
    endcase
  end

  // Datapath: capture in IDLE, step in SHIFT, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
      cnt_q  <= '0;
      op_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            cnt_q  <= in_amt;
            op_q   <= in_op;
          end
        end
        SHIFT: begin
          data_q <= step_data;
          cnt_q  <= cnt_q - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_word_unshift_iter.sv
// tb/tb_word_unshift_iter.sv - randomized self-checking bench for word_unshift_iter

module tb_word_unshift_iter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int total_cnt;
  int pass_cnt;

  word_unshift_iter #(
    .WIDTH(8),
    .AMT_W(3),
    .RESET_VAL(8'hFC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference: whole-word arithmetic on a doubled word, not bit stepping.
  function automatic logic [7:0] model(input logic [7:0] d, input int k, input logic [1:0] op);
    logic [15:0] dd;
    logic [15:0] t;
    logic [7:0]  r;
    dd = {d, d};
    case (op)
      2'b00: begin
        t = dd >> k;
        r = t[7:0];
      end
      2'b01: begin
        t = dd << k;
        r = t[15:8];
      end
      2'b10:   r = d >> k;
      default: r = d << k;
    endcase
    return r;
  endfunction

  // Runs one operation. stall = cycles out_ready is withheld once the result is up.
  task automatic do_op(input logic [7:0] d, input int k, input logic [1:0] op,
                       input int stall, output logic [7:0] res);
    int lat;
    logic [7:0] exp_v;
    exp_v = model(d, k, op);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = k[2:0];
    in_op     = op;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", lat, k);
    check("result", out_data, exp_v);
    check("busy_done", busy, 1);
    res = out_data;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_amt   = 3'($urandom);
        in_op    = 2'($urandom);
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, exp_v);
        check("stall_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    check("post_hs_hold", out_data, exp_v);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] r2;
    logic [7:0] d;
    int k;
    total_cnt = 0;
    pass_cnt  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_op     = 2'b00;
    out_ready = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 8'hFC);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(8'h81, 3, 2'b00, 0, r);
    check("rr_const", r, 8'h30);
    do_op(8'h30, 3, 2'b01, 0, r);
    check("rl_const", r, 8'h81);
    do_op(8'hF0, 5, 2'b10, 0, r);
    check("shr_const", r, 8'h07);
    do_op(8'h0F, 7, 2'b11, 0, r);
    check("shl_const", r, 8'h80);
    do_op(8'hFF, 0, 2'b11, 0, r);
    check("amt0_const", r, 8'hFF);

    // Backpressure with concurrent (ignored) input
    do_op(8'hA5, 4, 2'b00, 10, r);
    check("bp_const", r, 8'h5A);

    // Back-to-back with in_valid held continuously
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h81;
    in_amt    = 3'd3;
    in_op     = 2'b00;
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_a_captured", in_ready, 0);
    in_data = 8'h5A;
    in_amt  = 3'd2;
    in_op   = 2'b01;
    wait_valid("b2b_a_valid");
    check("b2b_a_result", out_data, 8'h30);
    @(negedge clk);
    check("b2b_idle_after_hs", in_ready, 1);
    @(negedge clk);
    check("b2b_b_captured", in_ready, 0);
    in_valid = 1'b0;
    wait_valid("b2b_b_valid");
    check("b2b_b_result", out_data, model(8'h5A, 2, 2'b01));
    @(negedge clk);

    // Reset in the middle of SHIFT
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h81;
    in_amt    = 3'd7;
    in_op     = 2'b00;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 8'hFC);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_out_valid", out_valid, 0);
    end
    rst = 1'b0;
    do_op(8'h81, 7, 2'b00, 0, r);
    check("after_rst_const", r, 8'h03);

    // Randomized operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), int'($urandom_range(0, 7)), 2'($urandom),
            int'($urandom_range(0, 3)), r);
    end

    // Inverse property: rotate left then rotate right by the same amount
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      k = i;
      do_op(d, k, 2'b01, 0, r);
      do_op(r, k, 2'b00, int'($urandom_range(0, 2)), r2);
      check("inverse", r2, d);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
